b05_peak_scanner: RTL and testbench

//  Parametrised successor to the b05 max/peak scanner. Reads DEPTH signed words from an

---
 rtl/b05_peak_scanner.sv | 154 +++++++++++++++
 tb/tb_b05_peak_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/b05_peak_scanner.sv
// b05_peak_scanner: scans DEPTH signed words from a synchronous-read memory.
// It tracks the running signed maximum and counts peaks (a rise followed later by a fall).
// The results are held for the display/decoder stage, and a start/done handshake frames each scan.
// Optional feature macro: B05_MIN_TRACK_EN adds a running signed minimum output min_val.
module b05_peak_scanner #(
    parameter int DW    = 9,
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int NUMW  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            busy,
    output logic            done,
    output logic            res_valid,
    output logic [DW-1:0]   max_val,
    output logic [NUMW-1:0] peak_cnt,
    output logic            sign
`ifdef B05_MIN_TRACK_EN
    ,
    output logic [DW-1:0]   min_val
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_LOAD0,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);
    localparam logic [NUMW-1:0] PK_MAX   = '1;
    localparam bit              ONE_WORD = (DEPTH == 1);

    state_t               state;
    logic [AW-1:0]        ptr;      // index of the word being processed in SCAN
    logic [AW-1:0]        rd_ptr;   // address currently being read
    logic signed [DW-1:0] temp;
    logic                 flag;
    logic signed [DW-1:0] d_s;
    logic                 last;

    assign d_s      = mem_data;
    assign last     = (ptr == LAST);
    // Read data returns one cycle after the strobe, so the address runs one word ahead of ptr.
    assign mem_addr = rd_ptr;
    assign sign     = res_valid & max_val[DW-1];

    // Read strobe decoded from state: the next word is requested while one is outstanding.
    always_comb begin
        mem_rd = 1'b0;
        case (state)
            S_ISSUE0: mem_rd = 1'b1;
            S_LOAD0:  mem_rd = !ONE_WORD;
            S_SCAN:   mem_rd = !last;
            default:  mem_rd = 1'b0;
        endcase
    end

    // Scan controller with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            rd_ptr    <= '0;
            temp      <= '0;
            flag      <= 1'b0;
            max_val   <= '0;
            peak_cnt  <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef B05_MIN_TRACK_EN
            min_val   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ISSUE0;
                        ptr       <= '0;
                        rd_ptr    <= '0;
                        peak_cnt  <= '0;
                        flag      <= 1'b0;
                        res_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE0: begin
                    state  <= S_LOAD0;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                S_LOAD0: begin
                    max_val <= mem_data;
                    temp    <= d_s;
`ifdef B05_MIN_TRACK_EN
                    min_val <= mem_data;
`endif
                    if (ONE_WORD) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        res_valid <= 1'b1;
                    end else begin
                        state  <= S_SCAN;
                        ptr    <= AW'(1);
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                S_SCAN: begin
                    temp <= d_s;
                    if (d_s < temp) begin
                        if (flag) begin
                            flag <= 1'b0;
                            if (peak_cnt != PK_MAX)
                                peak_cnt <= peak_cnt + 1'b1;
                        end
                    end else if (d_s > temp) begin
                        flag <= 1'b1;
                        if (d_s > $signed(max_val))
                            max_val <= mem_data;
                    end
`ifdef B05_MIN_TRACK_EN
                    if (d_s < $signed(min_val))
                        min_val <= mem_data;
`endif
                    if (last) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        res_valid <= 1'b1;
                    end else begin
                        ptr    <= ptr + 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    res_valid <= 1'b1;
                    if (!start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_b05_peak_scanner.sv
// Testbench for b05_peak_scanner: five instances (DEPTH 32/4/9/1/3, one with NUMW=2),
// each fed by a behavioural synchronous-read memory, checked against a list-based reference.
// With B05_MIN_TRACK_EN defined the min_val output is checked as well.
module tb_b05_peak_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] st  = '0;
    logic [4:0] rd, busy, done, rv, sg;
    logic [4:0] addr [5];
    logic [8:0] data [5];
    logic [8:0] mx   [5];
    logic [5:0] pk   [5];
    logic [1:0] pk_c;
`ifdef B05_MIN_TRACK_EN
    logic [8:0] mn   [5];
`endif

    logic signed [8:0] mem [5][32];
    int rd_cnt [5] = '{default: 0};
    int dep    [5] = '{32, 4, 9, 1, 3};
    int nw     [5] = '{6, 6, 2, 6, 6};
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pk[2] = {4'b0, pk_c};

    // Synchronous-read memory models, one per instance; also count read strobes.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rd[i]) begin
                data[i]   <= mem[i][addr[i]];
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    b05_peak_scanner #(.DW(9), .AW(5), .DEPTH(32), .NUMW(6)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .mem_rd(rd[0]), .mem_addr(addr[0]),
        .mem_data(data[0]), .busy(busy[0]), .done(done[0]), .res_valid(rv[0]),
        .max_val(mx[0]), .peak_cnt(pk[0]), .sign(sg[0])
`ifdef B05_MIN_TRACK_EN
        , .min_val(mn[0])
`endif
    );
    b05_peak_scanner #(.DW(9), .AW(5), .DEPTH(4), .NUMW(6)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .mem_rd(rd[1]), .mem_addr(addr[1]),
        .mem_data(data[1]), .busy(busy[1]), .done(done[1]), .res_valid(rv[1]),
        .max_val(mx[1]), .peak_cnt(pk[1]), .sign(sg[1])
`ifdef B05_MIN_TRACK_EN
        , .min_val(mn[1])
`endif
    );
    b05_peak_scanner #(.DW(9), .AW(5), .DEPTH(9), .NUMW(2)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .mem_rd(rd[2]), .mem_addr(addr[2]),
        .mem_data(data[2]), .busy(busy[2]), .done(done[2]), .res_valid(rv[2]),
        .max_val(mx[2]), .peak_cnt(pk_c), .sign(sg[2])
`ifdef B05_MIN_TRACK_EN
        , .min_val(mn[2])
`endif
    );
    b05_peak_scanner #(.DW(9), .AW(5), .DEPTH(1), .NUMW(6)) u_d (
        .clk(clk), .rst(rst), .start(st[3]), .mem_rd(rd[3]), .mem_addr(addr[3]),
        .mem_data(data[3]), .busy(busy[3]), .done(done[3]), .res_valid(rv[3]),
        .max_val(mx[3]), .peak_cnt(pk[3]), .sign(sg[3])
`ifdef B05_MIN_TRACK_EN
        , .min_val(mn[3])
`endif
    );
    b05_peak_scanner #(.DW(9), .AW(5), .DEPTH(3), .NUMW(6)) u_e (
        .clk(clk), .rst(rst), .start(st[4]), .mem_rd(rd[4]), .mem_addr(addr[4]),
        .mem_data(data[4]), .busy(busy[4]), .done(done[4]), .res_valid(rv[4]),
        .max_val(mx[4]), .peak_cnt(pk[4]), .sign(sg[4])
`ifdef B05_MIN_TRACK_EN
        , .min_val(mn[4])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: drop repeated neighbours, then count strict interior local maxima.
    function automatic void model(input int idx, output int emx, output int emn, output int epk);
        int q[$];
        int v;
        int lim;
        emx = mem[idx][0];
        emn = emx;
        for (int k = 0; k < dep[idx]; k++) begin
            v = mem[idx][k];
            if (v > emx) emx = v;
            if (v < emn) emn = v;
            if (q.size() == 0 || q[$] != v) q.push_back(v);
        end
        epk = 0;
        for (int k = 1; k < q.size() - 1; k++)
            if (q[k] > q[k-1] && q[k] > q[k+1]) epk++;
        lim = (1 << nw[idx]) - 1;
        if (epk > lim) epk = lim;
    endfunction

    task automatic chk_zero(input int idx);
        chk("rst_busy", busy[idx], 0);
        chk("rst_mem_rd", rd[idx], 0);
        chk("rst_mem_addr", addr[idx], 0);
        chk("rst_done", done[idx], 0);
        chk("rst_res_valid", rv[idx], 0);
        chk("rst_max_val", mx[idx], 0);
        chk("rst_peak_cnt", pk[idx], 0);
        chk("rst_sign", sg[idx], 0);
`ifdef B05_MIN_TRACK_EN
        chk("rst_min_val", mn[idx], 0);
`endif
    endtask

    // Runs one scan on instance idx; called #1 after a rising edge.
    task automatic run_scan(input int idx, input bit hold, input bit tog);
        int emx, emn, epk, rd0, lat;
        bit ok_during;
        model(idx, emx, emn, epk);
        st[idx]   = 1'b1;
        rd0       = rd_cnt[idx];
        lat       = -1;
        ok_during = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (done[idx]) begin
                lat = e;
                break;
            end
            if (rv[idx] !== 1'b0 || busy[idx] !== 1'b1) ok_during = 1'b0;
            if (tog) st[idx] = e[0];
        end
        chk("busy_and_res_valid_during_scan", ok_during, 1);
        chk("done_latency", lat, dep[idx] + 1);
        chk("res_valid", rv[idx], 1);
        chk("busy_at_done", busy[idx], 0);
        chk("max_val", mx[idx], emx & 32'h1FF);
        chk("peak_cnt", pk[idx], epk);
        chk("sign", sg[idx], emx < 0);
        chk("read_count", rd_cnt[idx] - rd0, dep[idx]);
`ifdef B05_MIN_TRACK_EN
        chk("min_val", mn[idx], emn & 32'h1FF);
`endif
        if (hold) begin
            st[idx] = 1'b1;
            repeat (4) begin @(posedge clk); #1; end
            chk("hold_done", done[idx], 0);
            chk("hold_busy", busy[idx], 0);
            chk("hold_res_valid", rv[idx], 1);
            chk("hold_no_reads", rd_cnt[idx] - rd0, dep[idx]);
        end
        st[idx] = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", done[idx], 0);
        chk("res_valid_kept", rv[idx], 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) chk_zero(i);
        rst = 1'b0;
        @(posedge clk); #1;

        // Rise, fall, rise: one peak.
        mem[1][0] = 9'sd5; mem[1][1] = 9'sd10; mem[1][2] = 9'sd3; mem[1][3] = 9'sd8;
        run_scan(1, 1'b0, 1'b0);

        // All-negative data.
        mem[4][0] = -9'sd10; mem[4][1] = -9'sd3; mem[4][2] = -9'sd20;
        run_scan(4, 1'b0, 1'b0);

        // Flat data: no peaks.
        for (int k = 0; k < 3; k++) mem[4][k] = 9'sd5;
        run_scan(4, 1'b0, 1'b0);

        // Alternating data saturates a 2-bit counter.
        for (int k = 0; k < 9; k++) mem[2][k] = 9'(k % 2);
        run_scan(2, 1'b0, 1'b0);

        // Single-word scan.
        mem[3][0] = 9'sd7;
        run_scan(3, 1'b0, 1'b0);

        // Randomised scans on the full-depth instance, including plateaus and extremes.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                case (r % 3)
                    0: mem[0][k] = 9'($urandom);
                    1: mem[0][k] = 9'(int'($urandom_range(0, 4)) - 2);
                    default: mem[0][k] = ($urandom_range(0, 1) == 1) ? 9'h0FF : 9'h100;
                endcase
            end
            run_scan(0, r == 1, r == 2);
        end

        // Randomised small-range scans against the saturating counter.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 9; k++) mem[2][k] = 9'(int'($urandom_range(0, 3)) - 1);
            run_scan(2, 1'b0, 1'b0);
        end

        // Held start: no second scan; then a fresh scan after start is dropped.
        for (int k = 0; k < 32; k++) mem[0][k] = 9'($urandom);
        run_scan(0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) mem[0][k] = 9'($urandom);
        run_scan(0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a scan.
        st[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_before_abort", busy[0], 1);
        rst = 1'b1;
        #1;
        chk_zero(0);
        st[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) mem[0][k] = 9'($urandom);
        run_scan(0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
